stream_rr_arbiter: RTL
======================

Name: stream_rr_arbiter

Overview:
Shares one valid/ready output stream between NUM_SRC packet sources using round-robin arbitration with packet locking. Once a source wins, it keeps the grant until its beat flagged last has transferred. A one-entry registered output stage drives the downstream consumer. The block sits ahead of the team's stream register slices so several producers can feed one slice/consumer chain, and it exports a beat counter and source tag for debug and routing.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
DW, 32, data width per beat
CW, 16, width of output beat counter
SW, $clog2(NUM_SRC) (derived, not overridable), width of source index

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
data_s  input  NUM_SRC*DW  source data, source i at bits [i*DW +: DW]
vld_s  input  NUM_SRC  per-source valid
last_s  input  NUM_SRC  per-source end-of-packet flag, qualified by vld_s
ready_s  output  NUM_SRC  per-source ready
data_m  output  DW  output data
last_m  output  1  output end-of-packet flag
src_m  output  SW  index of the source that produced the current output beat
vld_m  output  1  output valid
ready_m  input  1  downstream ready
cnt_o  output  CW  count of completed output beats (vld_m & ready_m)
busy  output  1  high while state is LOCK or vld_m is high

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, grant=0, vld_m=0, data_m=0, last_m=0, src_m=0, cnt_o=0. Any buffered beat is discarded. ready_s is 0 because state is IDLE.
- FSM, two states:
  - IDLE: if any vld_s is high, pick the first asserted index searching ptr, ptr+1, ... wrapping modulo NUM_SRC. Register it in grant and go to LOCK next cycle. If no vld_s is high, stay in IDLE. ready_s is all zero in IDLE.
  - LOCK: a granted beat transfers when vld_s[grant] and ready_s[grant] are both high. When a granted beat transfers with last_s[grant]=1: go to IDLE and set ptr=(grant+1) mod NUM_SRC. If NUM_SRC is not a power of two, wrap explicitly. Otherwise stay in LOCK.
- ready_s[i] is combinational: (state==LOCK) & (grant==i) & (!vld_m | ready_m). At most one bit is ever high.
- Output stage load: on a granted transfer, load data_m, last_m and src_m=grant, and set vld_m=1 at the next edge.
- Output stage hold: if vld_m & ready_m and no new load, clear vld_m. If vld_m & !ready_m, hold data_m, last_m and src_m stable.
- Simultaneous output drain and source transfer: the new beat replaces the old one with no bubble, so throughput inside a packet is 1 beat/cycle.
- Latency: first vld_s rises at cycle 0 → grant registered, ready_s high at cycle 1 → vld_m high at cycle 2. Between packets there is one IDLE arbitration cycle, even when other sources are waiting.
- Non-granted sources: vld_s is ignored and ready_s stays 0. Sources must hold data stable while waiting (standard valid/ready rule).
- Granted source drops vld_s mid-packet: the grant is held indefinitely, with no timeout and no preemption.
- A single-beat packet (last_s=1 on the first beat) is legal.
- cnt_o increments on every vld_m & ready_m. It wraps from 2^CW-1 to 0.
- busy = (state==LOCK) | vld_m.
- Reset asserted mid-packet: everything returns to reset values immediately, and the partial packet is lost.

Test Plan:
- Single source: NUM_SRC=4, source 2 sends 3 beats 0xA0,0xA1,0xA2 (last on the third) with ready_m=1 → vld_m first high 2 cycles after vld_s; outputs 0xA0..0xA2 on consecutive cycles; src_m=2; last_m on 0xA2; cnt_o=3; ptr=3.
- Fairness: sources 0 and 1 each continuously offer 2-beat packets → output packet order is 0,1,0,1. There is one idle cycle between packets, and no beats of the two sources are interleaved.
- Backpressure: during a 4-beat packet, hold ready_m=0 for 3 cycles mid-packet → data_m/last_m/src_m hold stable, ready_s[grant]=0 during the stall, no beat is lost or duplicated, and all 4 beats arrive in order.
- Pointer wrap: with ptr=3, sources 0 and 3 request simultaneously → source 3 wins; afterwards ptr=0, and source 0 wins next.
- Counter wrap: CW=4, send 17 beats → cnt_o goes 15 → 0, ending at 1.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4 → vld_m, cnt_o and ready_s go to 0 asynchronously. After release, the state is IDLE and the next arbitration starts from ptr=0.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between NUM_SRC packet sources, the arbiter and one downstream consumer.
// The arbiter takes the slave view; the environment driving sources and sinking output takes the master view.
interface stream_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 32
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC*DW-1:0] data_s;
  logic [NUM_SRC-1:0]    vld_s;
  logic [NUM_SRC-1:0]    last_s;
  logic [NUM_SRC-1:0]    ready_s;

  logic [DW-1:0]         data_m;
  logic                  last_m;
  logic [SW-1:0]         src_m;
  logic                  vld_m;
  logic                  ready_m;

  modport slave (
    input  data_s, vld_s, last_s, ready_m,
    output ready_s, data_m, last_m, src_m, vld_m
  );

  modport master (
    output data_s, vld_s, last_s, ready_m,
    input  ready_s, data_m, last_m, src_m, vld_m
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet-locking arbiter feeding a one-entry output register; first beat out 2 cycles after vld_s.
// Backpressure: ready_s of the granted source follows (!vld_m | ready_m); beat-per-cycle inside a packet.
module stream_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 32,
  parameter int CW      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_rr_arbiter_if.slave    s_if,
  output logic [CW-1:0]         cnt_o,
  output logic                  busy
);

  localparam int SW = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_ptr;
  logic [SW-1:0]     w_ptr_nxt;
  logic [SW-1:0]     r_grant;
  logic [SW-1:0]     w_grant_nxt;

  logic              w_req_any;
  logic [SW-1:0]     w_req_idx;
  logic [SW-1:0]     w_cand;

  logic              w_gnt_vld;
  logic              w_gnt_last;
  logic [DW-1:0]     w_gnt_data;
  logic              w_out_free;
  logic              w_xfer;
  logic [NUM_SRC-1:0] w_ready_s;

  logic              r_vld_m;
  logic [DW-1:0]     r_data_m;
  logic              r_last_m;
  logic [SW-1:0]     r_src_m;
  logic [CW-1:0]     r_cnt;

  // Wraps explicitly so non-power-of-two source counts never select a missing index.
  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) begin
      s = s - NUM_SRC;
    end
    return SW'(s);
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_cand = rr_idx(r_ptr, k);
      if (!w_req_any && s_if.vld_s[w_cand]) begin
        w_req_any = 1'b1;
        w_req_idx = w_cand;
      end
    end
  end

  assign w_gnt_vld  = s_if.vld_s[r_grant];
  assign w_gnt_last = s_if.last_s[r_grant];
  assign w_gnt_data = s_if.data_s[r_grant*DW +: DW];

  // The output register can accept a beat when empty or draining this cycle.
  assign w_out_free = !r_vld_m || s_if.ready_m;
  assign w_xfer     = (r_state == LOCK) && w_gnt_vld && w_out_free;

  always_comb begin
    w_ready_s = '0;
    if (r_state == LOCK && w_out_free) begin
      w_ready_s[r_grant] = 1'b1;
    end
  end

  assign s_if.ready_s = w_ready_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_grant_nxt = w_req_idx;
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        // Grant is held until the last beat moves; a stalled source keeps it indefinitely.
        if (w_xfer && w_gnt_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_grant == SW'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A new beat overwrites a draining one, so back-to-back beats leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_m  <= 1'b0;
      r_data_m <= '0;
      r_last_m <= 1'b0;
      r_src_m  <= '0;
    end else if (w_xfer) begin
      r_vld_m  <= 1'b1;
      r_data_m <= w_gnt_data;
      r_last_m <= w_gnt_last;
      r_src_m  <= r_grant;
    end else if (r_vld_m && s_if.ready_m) begin
      r_vld_m  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_vld_m && s_if.ready_m) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign s_if.vld_m  = r_vld_m;
  assign s_if.data_m = r_data_m;
  assign s_if.last_m = r_last_m;
  assign s_if.src_m  = r_src_m;
  assign cnt_o       = r_cnt;
  assign busy        = (r_state == LOCK) || r_vld_m;

endmodule
